// File: rtl/alu_seq_pkg.sv
// Shared constants, instruction layout and state encoding for the ALU sequencer.
// Opcode classification helpers live here so the top and the bench agree on decode.
package alu_seq_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_COUNT = 8;
    localparam int unsigned REG_AW    = 3;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned SH_W      = 3;
    localparam int unsigned SHAMT_W   = 5;
    localparam int unsigned FLAG_W    = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'h0;
    localparam logic [OP_W-1:0] OP_OR  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_LS  = 4'h3;
    localparam logic [OP_W-1:0] OP_SRS = 4'h4;
    localparam logic [OP_W-1:0] OP_URS = 4'h5;
    localparam logic [OP_W-1:0] OP_SUB = 4'h6;
    localparam logic [OP_W-1:0] OP_SLT = 4'h7;
    localparam logic [OP_W-1:0] OP_RRO = 4'h8;
    localparam logic [OP_W-1:0] OP_LRO = 4'h9;
    localparam logic [OP_W-1:0] OP_LDI = 4'hA;
    localparam logic [OP_W-1:0] OP_CMP = 4'hB;
    localparam logic [OP_W-1:0] OP_NOT = 4'hF;

    // Field positions: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] shamt; imm = [7:0].
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [SH_W-1:0]   shamt;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_LS, OP_SRS, OP_URS,
            OP_SUB, OP_SLT, OP_RRO, OP_LRO, OP_NOT: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return !is_alu_op(op) && (op != OP_LDI) && (op != OP_CMP);
    endfunction

    function automatic logic [DATA_W-1:0] imm_of(input instr_t ins);
        return DATA_W'(ins);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 8x8 register file: two operand read ports, one debug read port, one write port.
// Entry 0 always reads zero and ignores writes.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = REG_COUNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    input  logic [REG_AW-1:0] raddr_dbg_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] rdata_dbg_o
);

    logic [DATA_W-1:0] regs_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(input logic [REG_AW-1:0] a);
        return (a == '0) ? '0 : regs_q[a];
    endfunction

    assign rdata_a_o   = rd_port(raddr_a_i);
    assign rdata_b_o   = rd_port(raddr_b_i);
    assign rdata_dbg_o = rd_port(raddr_dbg_i);

endmodule

// File: rtl/alu_sequencer.sv
// Three-cycle instruction sequencer (IDLE -> EXEC -> WB) driving an external 8-bit ALU
// and committing results/flags to a local register file.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [INSTR_W-1:0]  instr,
    output logic [DATA_W-1:0]   alu_ina,
    output logic [DATA_W-1:0]   alu_inb,
    output logic [OP_W-1:0]     alu_op,
    output logic [SHAMT_W-1:0]  alu_shamt,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_cr,
    input  logic                alu_ov,
    input  logic                alu_ng,
    input  logic                alu_zr,
    output logic [FLAG_W-1:0]   flags,
    output logic                done,
    output logic                illegal,
    input  logic [REG_AW-1:0]   dbg_raddr,
    output logic [DATA_W-1:0]   dbg_rdata
);

    state_e              state_q, state_d;
    instr_t              instr_q, instr_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [FLAG_W-1:0]   cap_flags_q, cap_flags_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;
    logic                wb_we_c;
    logic [DATA_W-1:0]   wb_data_c;
    logic [DATA_W-1:0]   rs_data_c, rt_data_c;

    alu_seq_regfile #(
        .DEPTH (NUM_REGS)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .we_i        (wb_we_c),
        .waddr_i     (instr_q.rd),
        .wdata_i     (wb_data_c),
        .raddr_a_i   (instr_q.rs),
        .raddr_b_i   (instr_q.rt),
        .raddr_dbg_i (dbg_raddr),
        .rdata_a_o   (rs_data_c),
        .rdata_b_o   (rt_data_c),
        .rdata_dbg_o (dbg_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            res_q       <= '0;
            cap_flags_q <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            res_q       <= res_d;
            cap_flags_q <= cap_flags_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
        end
    end

    // done/illegal are set on the EXEC->WB edge so they are high for the whole WB cycle.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        res_d       = res_q;
        cap_flags_d = cap_flags_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        wb_we_c     = 1'b0;
        wb_data_c   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr_t'(instr);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d       = alu_out;
                cap_flags_d = {alu_cr, alu_ov, alu_ng, alu_zr};
                done_d      = 1'b1;
                illegal_d   = is_illegal_op(instr_q.op);
                state_d     = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
                if (instr_q.op == OP_LDI) begin
                    wb_we_c   = 1'b1;
                    wb_data_c = imm_of(instr_q);
                end else if (is_alu_op(instr_q.op)) begin
                    wb_we_c = 1'b1;
                    flags_d = cap_flags_q;
                end else if (instr_q.op == OP_CMP) begin
                    flags_d = cap_flags_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU operand bus is quiet (all zero) except during EXEC.
    always_comb begin
        alu_ina   = '0;
        alu_inb   = '0;
        alu_op    = OP_AND;
        alu_shamt = '0;
        if (state_q == ST_EXEC) begin
            alu_ina   = rs_data_c;
            alu_inb   = rt_data_c;
            alu_shamt = {2'b00, instr_q.shamt};
            if (is_alu_op(instr_q.op)) begin
                alu_op = instr_q.op;
            end else if (instr_q.op == OP_CMP) begin
                alu_op = OP_SUB;
            end
        end
    end

    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign flags       = flags_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU on the alu_* ports.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_ina, alu_inb, alu_out;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic        alu_cr, alu_ov, alu_ng, alu_zr;
    logic [3:0]  flags;
    logic        done, illegal;
    logic [2:0]  dbg_raddr;
    logic [7:0]  dbg_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_ina     (alu_ina),
        .alu_inb     (alu_inb),
        .alu_op      (alu_op),
        .alu_shamt   (alu_shamt),
        .alu_out     (alu_out),
        .alu_cr      (alu_cr),
        .alu_ov      (alu_ov),
        .alu_ng      (alu_ng),
        .alu_zr      (alu_zr),
        .flags       (flags),
        .done        (done),
        .illegal     (illegal),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata)
    );

    // External ALU: carry/overflow only meaningful for ADD/SUB.
    logic [7:0]  m_res;
    logic        m_cr, m_ov;
    logic [8:0]  m_wide;
    logic [15:0] m_dbl;
    always_comb begin
        m_res  = '0;
        m_cr   = 1'b0;
        m_ov   = 1'b0;
        m_wide = '0;
        m_dbl  = {alu_ina, alu_ina};
        case (alu_op)
            4'h0: m_res = alu_ina & alu_inb;
            4'h1: m_res = alu_ina | alu_inb;
            4'h2: begin
                m_wide = {1'b0, alu_ina} + {1'b0, alu_inb};
                m_res  = m_wide[7:0];
                m_cr   = m_wide[8];
                m_ov   = (alu_ina[7] == alu_inb[7]) && (m_res[7] != alu_ina[7]);
            end
            4'h3: m_res = alu_ina << alu_shamt;
            4'h4: m_res = $signed(alu_ina) >>> alu_shamt;
            4'h5: m_res = alu_ina >> alu_shamt;
            4'h6: begin
                m_res = alu_ina - alu_inb;
                m_cr  = alu_ina < alu_inb;
                m_ov  = (alu_ina[7] != alu_inb[7]) && (m_res[7] != alu_ina[7]);
            end
            4'h7: m_res = {7'd0, $signed(alu_ina) < $signed(alu_inb)};
            4'h8: m_res = 8'(m_dbl >> alu_shamt[2:0]);
            4'h9: m_res = 8'(m_dbl >> (4'd8 - {1'b0, alu_shamt[2:0]}));
            4'hF: m_res = ~alu_ina;
            default: m_res = '0;
        endcase
    end
    assign alu_out = m_res;
    assign alu_cr  = m_cr;
    assign alu_ov  = m_ov;
    assign alu_ng  = m_res[7];
    assign alu_zr  = (m_res == 8'h00);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] ins;
        logic        ill;
        logic        chk_alu;
        logic [3:0]  op;
        logic [7:0]  ina;
        logic [7:0]  inb;
        logic [4:0]  sh;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [3:0]  flg;
    } vec_t;

    // Accept at E0, check EXEC bus, check done/illegal in WB, then register and flags.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        chk($sformatf("v%0d_idle_ready", idx), 32'(instr_ready), 32'd1);
        chk($sformatf("v%0d_idle_alu_zero", idx), 32'({alu_ina, alu_inb, alu_op, alu_shamt}), 32'd0);
        instr_valid = 1'b1;
        instr       = v.ins;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = ~v.ins;
        chk($sformatf("v%0d_exec_ready", idx), 32'(instr_ready), 32'd0);
        chk($sformatf("v%0d_exec_done", idx), 32'(done), 32'd0);
        if (v.chk_alu)
            chk($sformatf("v%0d_exec_alu", idx), 32'({alu_ina, alu_inb, alu_op, alu_shamt}),
                32'({v.ina, v.inb, v.op, v.sh}));
        @(negedge clk);
        chk($sformatf("v%0d_wb_done_illegal", idx), 32'({done, illegal}), 32'({1'b1, v.ill}));
        chk($sformatf("v%0d_wb_alu_zero", idx), 32'({alu_ina, alu_inb, alu_op, alu_shamt}), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_post_pulse", idx), 32'({done, illegal}), 32'd0);
        dbg_raddr = v.addr;
        #1;
        chk($sformatf("v%0d_reg", idx), 32'(dbg_rdata), 32'(v.data));
        chk($sformatf("v%0d_flags", idx), 32'(flags), 32'(v.flg));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [11];
        int   last;
        int   n_acc;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_raddr   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_low", 32'(instr_ready), 32'd0);
        chk("rst_outputs", 32'({done, illegal, flags}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        dbg_raddr = 3'd1;
        #1;
        chk("rst_ready_high", 32'(instr_ready), 32'd1);
        chk("rst_r1_zero", 32'(dbg_rdata), 32'd0);

        //          ins       ill   alu   op    ina    inb    sh    addr  data   flg
        vecs[0]  = '{16'hA27F, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 5'd0, 3'd1, 8'h7F, 4'b0000}; // LDI R1,7F
        vecs[1]  = '{16'hA401, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 5'd0, 3'd2, 8'h01, 4'b0000}; // LDI R2,01
        vecs[2]  = '{16'h2650, 1'b0, 1'b1, 4'h2, 8'h7F, 8'h01, 5'd0, 3'd3, 8'h80, 4'b0110}; // ADD R3,R1,R2
        vecs[3]  = '{16'h6890, 1'b0, 1'b1, 4'h6, 8'h01, 8'h01, 5'd0, 3'd4, 8'h00, 4'b0001}; // SUB R4,R2,R2
        vecs[4]  = '{16'hC000, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 5'd0, 3'd4, 8'h00, 4'b0001}; // illegal
        vecs[5]  = '{16'hE650, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 5'd0, 3'd3, 8'h80, 4'b0001}; // illegal, rd=R3
        vecs[6]  = '{16'hB050, 1'b0, 1'b1, 4'h6, 8'h7F, 8'h01, 5'd0, 3'd1, 8'h7F, 4'b0000}; // CMP R0,R1,R2
        vecs[7]  = '{16'hA055, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 5'd0, 3'd0, 8'h00, 4'b0000}; // LDI R0,55
        vecs[8]  = '{16'h3C43, 1'b0, 1'b1, 4'h3, 8'h7F, 8'h00, 5'd3, 3'd6, 8'hF8, 4'b0010}; // LS R6,R1,3
        vecs[9]  = '{16'hFEC0, 1'b0, 1'b1, 4'hF, 8'h80, 8'h00, 5'd0, 3'd7, 8'h7F, 4'b0000}; // NOT R7,R3
        vecs[10] = '{16'h2250, 1'b0, 1'b1, 4'h2, 8'h7F, 8'h01, 5'd0, 3'd1, 8'h80, 4'b0110}; // ADD R1,R1,R2

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back offers: LDI R5,0x11 held valid for 12 cycles.
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'hAA11;
        last        = -1;
        n_acc       = 0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("cont_ready_%0d", i), 32'(instr_ready), 32'((i % 3) == 0));
            chk($sformatf("cont_done_%0d", i), 32'(done), 32'((i % 3) == 2));
            if (instr_ready) begin
                if (last >= 0) chk($sformatf("cont_gap_%0d", i), 32'(i - last), 32'd3);
                last = i;
                n_acc++;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("cont_accepts", 32'(n_acc), 32'd4);
        dbg_raddr = 3'd5;
        #1;
        chk("cont_r5", 32'(dbg_rdata), 32'h11);

        // Reset during EXEC of ADD R5,R1,R2 aborts it.
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = 16'h2A50;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("abort_in_exec", 32'(alu_op), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_in_rst", 32'(instr_ready), 32'd0);
        chk("abort_no_done", 32'({done, illegal}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        dbg_raddr = 3'd5;
        #1;
        chk("abort_idle", 32'(instr_ready), 32'd1);
        chk("abort_r5", 32'(dbg_rdata), 32'd0);
        chk("abort_flags_done", 32'({flags, done}), 32'd0);
        dbg_raddr = 3'd1;
        #1;
        chk("abort_r1_cleared", 32'(dbg_rdata), 32'd0);
        @(negedge clk);
        chk("abort_still_no_done", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
